// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, ID-branch flush and D-cache miss handshake.
// Optional saturating performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             memread_idex_i,
    input  logic [4:0]       rd_idex_i,
    input  logic [4:0]       rs1_ifid_i,
    input  logic [4:0]       rs2_ifid_i,
    input  logic             id_equal_i,
    input  logic             is_branch_i,
    input  logic             exmem_memaccess_i,
    input  logic             dcache_hit_i,
    input  logic             dcache_fill_ack_i,
    output logic             pc_write_o,
    output logic             ifid_stall_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_freeze_o,
    output logic             dcache_fill_req_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    typedef enum logic [1:0] {IDLE, RUN, MISS_REQ, MISS_DONE} state_t;

    state_t state_reg, state_next;
    logic   fill_req_reg;

    logic miss, branch_flush, load_use;

    assign miss         = exmem_memaccess_i & ~dcache_hit_i;
    assign branch_flush = id_equal_i & is_branch_i;
    assign load_use     = memread_idex_i && (rd_idex_i != 5'd0) &&
                          ((rd_idex_i == rs1_ifid_i) || (rd_idex_i == rs2_ifid_i));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg    <= IDLE;
            fill_req_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fill_req_reg <= (state_next == MISS_REQ);
        end
    end

    // Default is the frozen pattern shared by IDLE, a detected miss, MISS_REQ and MISS_DONE.
    always_comb begin
        state_next    = state_reg;
        pc_write_o    = 1'b0;
        ifid_stall_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_freeze_o = 1'b1;
        case (state_reg)
            IDLE: begin
                if (start_i) state_next = RUN;
            end
            RUN: begin
                if (miss) begin
                    state_next = MISS_REQ;
                end else if (branch_flush) begin
                    pc_write_o    = 1'b1;
                    ifid_stall_o  = 1'b0;
                    ifid_flush_o  = 1'b1;
                    idex_bubble_o = 1'b1;
                    pipe_freeze_o = 1'b0;
                end else if (load_use) begin
                    idex_bubble_o = 1'b1;
                    pipe_freeze_o = 1'b0;
                end else begin
                    pc_write_o    = 1'b1;
                    ifid_stall_o  = 1'b0;
                    pipe_freeze_o = 1'b0;
                end
            end
            MISS_REQ: begin
                if (dcache_fill_ack_i) state_next = MISS_DONE;
            end
            MISS_DONE: begin
                state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dcache_fill_req_o = fill_req_reg;

`ifdef PIPE_PERF_CNT_EN
    logic             stall_evt, flush_evt, miss_evt;
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg, miss_cnt_reg;

    assign miss_evt  = (state_reg == RUN) & miss;
    assign flush_evt = (state_reg == RUN) & ~miss & branch_flush;
    assign stall_evt = (state_reg == RUN) & ~miss & ~branch_flush & load_use;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
            miss_cnt_reg  <= '0;
        end else begin
            if (stall_evt && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (flush_evt && (flush_cnt_reg != '1)) flush_cnt_reg <= flush_cnt_reg + 1'b1;
            if (miss_evt  && (miss_cnt_reg  != '1)) miss_cnt_reg  <= miss_cnt_reg  + 1'b1;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
    assign flush_cnt_o = flush_cnt_reg;
    assign miss_cnt_o  = miss_cnt_reg;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
    assign miss_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Table-driven bench for pipeline_ctrl with a scoreboard queue of expected control patterns.
// Counter expectations follow PIPE_PERF_CNT_EN; without it the counters must read 0.
module tb_pipeline_ctrl;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    // Control pattern bit order: {pc_write, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, fill_req}
    localparam logic [5:0] E_IDLE  = 6'b010010;
    localparam logic [5:0] E_RUN   = 6'b100000;
    localparam logic [5:0] E_STALL = 6'b010100;
    localparam logic [5:0] E_FLUSH = 6'b101100;
    localparam logic [5:0] E_FRZ   = 6'b010010;
    localparam logic [5:0] E_REQ   = 6'b010011;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic start_i = 1'b0, memread_idex_i = 1'b0, id_equal_i = 1'b0, is_branch_i = 1'b0;
    logic [4:0] rd_idex_i = '0, rs1_ifid_i = '0, rs2_ifid_i = '0;
    logic exmem_memaccess_i = 1'b0, dcache_hit_i = 1'b1, dcache_fill_ack_i = 1'b0;
    logic pc_write_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o, dcache_fill_req_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o, miss_cnt_o;
    logic [5:0] ctl;

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .memread_idex_i(memread_idex_i), .rd_idex_i(rd_idex_i),
        .rs1_ifid_i(rs1_ifid_i), .rs2_ifid_i(rs2_ifid_i),
        .id_equal_i(id_equal_i), .is_branch_i(is_branch_i),
        .exmem_memaccess_i(exmem_memaccess_i), .dcache_hit_i(dcache_hit_i),
        .dcache_fill_ack_i(dcache_fill_ack_i),
        .pc_write_o(pc_write_o), .ifid_stall_o(ifid_stall_o), .ifid_flush_o(ifid_flush_o),
        .idex_bubble_o(idex_bubble_o), .pipe_freeze_o(pipe_freeze_o),
        .dcache_fill_req_o(dcache_fill_req_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    assign ctl = {pc_write_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o, dcache_fill_req_o};

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       start, memread, eq, br, memacc, hit;
        logic [4:0] rd, rs1, rs2;
        logic [5:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [5:0] ctl;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   m_stall = 0, m_flush = 0, m_miss = 0;

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    // One clock cycle: inputs already driven; compare at the falling edge.
    task automatic cycle(input string name, input logic [5:0] e);
        exp_t r;
        r.name = name;
        r.ctl  = e;
        sb.push_back(r);
        if (e == E_STALL) m_stall = sat_inc(m_stall);
        if (e == E_FLUSH) m_flush = sat_inc(m_flush);
        @(negedge clk);
        r = sb.pop_front();
        n_vec++;
        if (ctl !== r.ctl) begin
            n_bad++;
            $display("FAIL %s: ctl got %b want %b", r.name, ctl, r.ctl);
        end else begin
            $display("  %s: ctl=%b ok", r.name, ctl);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end else begin
            $display("  %s: %0d ok", name, act);
        end
    endtask

    task automatic check_cnts(input string tag);
        int es, ef, em;
`ifdef PIPE_PERF_CNT_EN
        es = m_stall; ef = m_flush; em = m_miss;
`else
        es = 0; ef = 0; em = 0;
`endif
        check_val({tag, " stall_cnt"}, int'(stall_cnt_o), es);
        check_val({tag, " flush_cnt"}, int'(flush_cnt_o), ef);
        check_val({tag, " miss_cnt"},  int'(miss_cnt_o),  em);
    endtask

    task automatic clear_inputs();
        start_i = 0; memread_idex_i = 0; id_equal_i = 0; is_branch_i = 0;
        rd_idex_i = 0; rs1_ifid_i = 0; rs2_ifid_i = 0;
        exmem_memaccess_i = 0; dcache_hit_i = 1; dcache_fill_ack_i = 0;
    endtask

    task automatic start_run();
        clear_inputs();
        start_i = 1;
        cycle("idle_start", E_IDLE);
        start_i = 0;
        cycle("run_first", E_RUN);
    endtask

    vec_t vecs[10];

    initial begin
        //            name         st mr eq br ma hit rd   rs1  rs2  exp
        vecs[0] = '{"nop_start", 1, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, E_RUN};
        vecs[1] = '{"lu_rs2",    0, 1, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, E_STALL};
        vecs[2] = '{"lu_rs1",    0, 1, 0, 0, 0, 1, 5'd7, 5'd7, 5'd2, E_STALL};
        vecs[3] = '{"lu_rd0",    0, 1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, E_RUN};
        vecs[4] = '{"no_load",   0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd5, E_RUN};
        vecs[5] = '{"lu_nomatch",0, 1, 0, 0, 0, 1, 5'd9, 5'd8, 5'd10, E_RUN};
        vecs[6] = '{"flush_lu",  0, 1, 1, 1, 0, 1, 5'd5, 5'd1, 5'd5, E_FLUSH};
        vecs[7] = '{"eq_nobr",   0, 0, 1, 0, 0, 1, 5'd0, 5'd0, 5'd0, E_RUN};
        vecs[8] = '{"br_noeq",   0, 0, 0, 1, 0, 1, 5'd0, 5'd0, 5'd0, E_RUN};
        vecs[9] = '{"acc_hit",   0, 0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0, E_RUN};

        // Asynchronous reset with no clock edge yet.
        #1 rst_i = 0;
        #2;
        check_val("reset ctl", int'(ctl), int'(E_IDLE));
        check_cnts("reset");
        @(negedge clk);
        rst_i = 1;
        @(posedge clk);
        #1;

        cycle("idle_hold", E_IDLE);
        start_run();

        for (int i = 0; i < 10; i++) begin
            start_i = vecs[i].start; memread_idex_i = vecs[i].memread;
            id_equal_i = vecs[i].eq; is_branch_i = vecs[i].br;
            exmem_memaccess_i = vecs[i].memacc; dcache_hit_i = vecs[i].hit;
            rd_idex_i = vecs[i].rd; rs1_ifid_i = vecs[i].rs1; rs2_ifid_i = vecs[i].rs2;
            cycle(vecs[i].name, vecs[i].exp);
        end
        clear_inputs();
        check_cnts("table");

        // Miss with ack four cycles after request; hazards during the freeze are suppressed.
        exmem_memaccess_i = 1; dcache_hit_i = 0;
        cycle("miss_detect", E_FRZ);
        m_miss = sat_inc(m_miss);
        cycle("miss_req1", E_REQ);
        id_equal_i = 1; is_branch_i = 1;
        cycle("miss_req2", E_REQ);
        memread_idex_i = 1; rd_idex_i = 5'd3; rs1_ifid_i = 5'd3;
        cycle("miss_req3", E_REQ);
        dcache_fill_ack_i = 1;
        cycle("miss_req4", E_REQ);
        dcache_fill_ack_i = 0; dcache_hit_i = 1;
        cycle("miss_done", E_FRZ);
        cycle("miss_replay", E_FLUSH);
        clear_inputs();
        cycle("after_miss", E_RUN);
        check_cnts("miss");

        // Ack already high (ignored in RUN), accepted on the first request cycle.
        exmem_memaccess_i = 1; dcache_hit_i = 0; dcache_fill_ack_i = 1;
        cycle("early_detect", E_FRZ);
        m_miss = sat_inc(m_miss);
        cycle("early_req", E_REQ);
        dcache_hit_i = 1;
        cycle("early_done", E_FRZ);
        dcache_fill_ack_i = 0;
        cycle("early_run", E_RUN);
        check_cnts("early");

        // Reset while the request is outstanding.
        exmem_memaccess_i = 1; dcache_hit_i = 0;
        cycle("rst_detect", E_FRZ);
        m_miss = sat_inc(m_miss);
        #2;
        check_val("pre_rst req", int'(dcache_fill_req_o), 1);
        rst_i = 0;
        m_stall = 0; m_flush = 0; m_miss = 0;
        #1;
        check_val("rst_in_miss ctl", int'(ctl), int'(E_IDLE));
        check_cnts("rst_in_miss");
        clear_inputs();
        @(negedge clk);
        rst_i = 1;
        @(posedge clk);
        #1;
        cycle("rst_idle", E_IDLE);

        // Saturation of the stall counter.
        start_run();
        memread_idex_i = 1; rd_idex_i = 5'd5; rs2_ifid_i = 5'd5;
        for (int i = 0; i < (1 << CNT_W) + 3; i++) cycle("sat_lu", E_STALL);
        clear_inputs();
        check_cnts("sat");
        check_val("sat model", m_stall, CMAX);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage RISC-V pipeline. It merges load-use hazard detection, taken-branch flushing in ID and data-cache miss handling into one prioritised set of pipeline-register controls. It owns the miss handshake with the data-cache fill engine. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their write-enable, flush and bubble selects.

## Interface
- CNT_W, 32, width of each performance counter (only meaningful with PIPE_PERF_CNT_EN)

- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  begin execution; sampled in IDLE only
- memread_idex_i  in  1  ID/EX instruction is a load
- rd_idex_i  in  5  ID/EX destination register
- rs1_ifid_i, rs2_ifid_i  in  5 each  IF/ID source registers
- id_equal_i  in  1  ID-stage branch comparator says equal
- is_branch_i  in  1  IF/ID instruction is a branch
- exmem_memaccess_i  in  1  EX/MEM instruction is a load or store
- dcache_hit_i  in  1  combinational hit for the current EX/MEM access
- dcache_fill_ack_i  in  1  fill engine done; valid only in MISS_REQ
- pc_write_o  out  1  PC write enable
- ifid_stall_o  out  1  hold IF/ID
- ifid_flush_o  out  1  clear IF/ID
- idex_bubble_o  out  1  select NOP controls into ID/EX
- pipe_freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB
- dcache_fill_req_o  out  1  registered miss request to the fill engine
- stall_cnt_o, flush_cnt_o, miss_cnt_o  out  CNT_W each  performance counters

## Operation
- FSM states: IDLE, RUN, MISS_REQ, MISS_DONE. Reset forces IDLE.
- IDLE:
  - pc_write_o=0, ifid_stall_o=1, pipe_freeze_o=1. All other control outputs are 0.
  - start_i=1 moves to RUN.
- RUN:
  - A miss is exmem_memaccess_i & ~dcache_hit_i. It takes top priority and is combinational in the same cycle: pc_write_o=0, ifid_stall_o=1, pipe_freeze_o=1, ifid_flush_o=0, idex_bubble_o=0. Next state is MISS_REQ.
  - Otherwise, a branch flush is id_equal_i & is_branch_i: pc_write_o=1, ifid_flush_o=1, idex_bubble_o=1, ifid_stall_o=0.
  - Otherwise, a load-use stall is memread_idex_i & rd_idex_i!=0 & (rd_idex_i==rs1_ifid_i | rd_idex_i==rs2_ifid_i): pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1.
  - Otherwise: pc_write_o=1 and all other control outputs are 0.
- MISS_REQ:
  - Outputs are frozen as in the RUN miss case.
  - dcache_fill_req_o=1 and is held until dcache_fill_ack_i is sampled high, which moves the FSM to MISS_DONE.
- MISS_DONE:
  - Frozen for exactly one cycle while the fill writes the cache. dcache_fill_req_o=0.
  - Next state is RUN, where the replayed access hits.
- dcache_fill_ack_i is ignored outside MISS_REQ.
- start_i is ignored outside IDLE. Only reset returns the FSM to IDLE.

## Timing
- Hazard and flush outputs are combinational from the inputs and the current state, so they take effect in the same cycle.
- dcache_fill_req_o is registered:
  - It rises on the first clock edge after the miss is detected.
  - It falls on the edge that samples the ack.
- Minimum miss penalty is 3 frozen cycles: detect, one MISS_REQ cycle, MISS_DONE.
- An ack that is already high on the first MISS_REQ cycle is accepted.
- Reset values, applied asynchronously:
  - pc_write_o=0, ifid_stall_o=1, pipe_freeze_o=1.
  - ifid_flush_o, idex_bubble_o and dcache_fill_req_o are 0.
  - All counters are 0.
- Reset during MISS_REQ drops dcache_fill_req_o immediately. The fill engine must tolerate an abandoned request.
- Simultaneous branch flush and load-use stall: the flush wins.
- Any event during a miss or freeze is suppressed and re-evaluated after MISS_DONE.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - stall_cnt_o increments on each RUN cycle that applies a load-use stall.
  - flush_cnt_o increments on each RUN cycle that applies a branch flush.
  - miss_cnt_o increments on each RUN to MISS_REQ transition.
  - All counters saturate at all-ones and clear only on reset.
- Not defined: the counter ports remain and are tied to 0, and no counter flops are synthesised.

## Test plan
- Reset, then start_i=1 for one cycle → pc_write_o goes 0→1 on the next cycle and pipe_freeze_o goes 1→0.
- RUN with memread_idex_i=1, rd_idex_i=5, rs2_ifid_i=5 → pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1. With rd_idex_i=0 there is no stall.
- Load-use condition plus id_equal_i=1 and is_branch_i=1 in the same cycle → ifid_flush_o=1, pc_write_o=1, ifid_stall_o=0. With PIPE_PERF_CNT_EN, flush_cnt_o=1 and stall_cnt_o=0.
- exmem_memaccess_i=1, dcache_hit_i=0, ack returned 4 cycles after the request rises → freeze for 6 cycles total, request high for exactly 4 cycles, miss_cnt_o=1, RUN resumes.
- Assert rst_i=0 while in MISS_REQ → dcache_fill_req_o=0 immediately, FSM returns to IDLE, counters cleared.
- Drive 2^CNT_W+3 load-use cycles with CNT_W=4 → stall_cnt_o holds at 15.
